// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix-keypad front end.
// key_map turns a (row, column) position into the 4-bit code the adder consumes.
package keypad_pkg;

    typedef logic [3:0] key_t;

    localparam key_t KEY_NONE = 4'hF;
    localparam key_t KEY_STAR = 4'hA;
    localparam key_t KEY_HASH = 4'hB;
    localparam key_t KEY_ZERO = 4'h0;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    // Rows 0-2 are the digits 1-9; row 3 is '*', '0', '#'.
    function automatic key_t key_map(input logic [1:0] r, input logic [1:0] c);
        key_t k;
        if (r != 2'd3) begin
            k = key_t'({2'b00, r} * 4'd3 + {2'b00, c} + 4'd1);
        end else begin
            case (c)
                2'd0:    k = KEY_STAR;
                2'd1:    k = KEY_ZERO;
                default: k = KEY_HASH;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous inputs such as keypad rows.
// Both stages reset to RST_VAL so idle (pulled-up) inputs read as inactive.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// Column-scanning 4x3 keypad reader: one result per 3-column frame, debounced
// over DEBOUNCE_SCANS identical frames, with a strobe for each new key code.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] sample,
    output logic       key_strobe
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        hits_q, hits_d;      // keys seen so far this frame, 2 means "two or more"
    key_t              code_q, code_d;
    key_t              cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    key_t              sample_q, sample_d;
    logic              strobe_q, strobe_d;

    logic [3:0] row_s;
    logic       slot_last;
    logic       frame_end;
    logic [1:0] slot_hits;
    key_t       slot_code;
    logic [1:0] base_hits;
    key_t       base_code;
    logic [2:0] hit_sum;
    logic [1:0] total_hits;
    key_t       total_code;
    key_t       frame_res;

    sync_2ff #(
        .WIDTH   (NUM_ROWS),
        .RST_VAL ('1)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row),
        .q_o (row_s)
    );

    assign slot_last = (slot_q == SLOT_LAST);
    assign frame_end = slot_last && (col_idx_q == 2'd2);

    // Keys found in the column currently being captured.
    always_comb begin
        slot_hits = 2'd0;
        slot_code = KEY_NONE;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_s[r]) begin
                slot_code = key_map(2'(r), col_idx_q);
                if (slot_hits != 2'd2) begin
                    slot_hits = slot_hits + 2'd1;
                end
            end
        end
    end

    // Column 0 starts a fresh frame; later columns add to the running tally.
    always_comb begin
        base_hits  = (col_idx_q == 2'd0) ? 2'd0 : hits_q;
        base_code  = (col_idx_q == 2'd0) ? KEY_NONE : code_q;
        hit_sum    = {1'b0, base_hits} + {1'b0, slot_hits};
        total_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        total_code = (slot_hits != 2'd0) ? slot_code : base_code;
        frame_res  = (total_hits == 2'd1) ? total_code : KEY_NONE;
    end

    always_comb begin
        slot_d    = slot_q + SLOT_W'(1);
        col_idx_d = col_idx_q;
        hits_d    = hits_q;
        code_d    = code_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        strobe_d  = 1'b0;

        if (slot_last) begin
            slot_d    = '0;
            col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
            hits_d    = total_hits;
            code_d    = total_code;
        end

        if (frame_end) begin
            if (frame_res != cand_q) begin
                cand_d = frame_res;
                cnt_d  = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // Release updates sample silently; only real keys strobe.
            if ((cnt_d == CNT_MAX) && (cand_d != sample_q)) begin
                sample_d = cand_d;
                strobe_d = (cand_d != KEY_NONE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= '0;
            col_idx_q <= 2'd0;
            hits_q    <= 2'd0;
            code_q    <= KEY_NONE;
            cand_q    <= KEY_NONE;
            cnt_q     <= '0;
            sample_q  <= KEY_NONE;
            strobe_q  <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            col_idx_q <= col_idx_d;
            hits_q    <= hits_d;
            code_q    <= code_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            strobe_q  <= strobe_d;
        end
    end

    assign col        = ~(3'b001 << col_idx_q);
    assign sample     = sample_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with a resistive keypad model, scenario tasks and a
// key-code table model that predicts settled samples and the strobe sequence.
module tb_keypad_scan;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int FRAME          = 3 * SCAN_DIV;
    localparam int LATENCY        = (DEBOUNCE_SCANS + 1) * FRAME + 3;
    localparam logic [3:0] NONE   = 4'hF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] sample;
    logic       key_strobe;

    // Keypad position r*3+c is held when pressed[r*3+c] is set.
    logic [11:0] pressed = '0;
    logic [3:0]  key_code [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                   4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

    int         checks     = 0;
    int         errors     = 0;
    int         strobe_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_sample = NONE;
    logic [3:0] mon_exp;
    logic       prev_strobe = 1'b0;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .sample     (sample),
        .key_strobe (key_strobe)
    );

    // ---------------- clock / keypad model ----------------
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r*3+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (key_strobe) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: strobe with sample=%h, none expected", sample);
            end else begin
                mon_exp = exp_q.pop_front();
                if (sample !== mon_exp) begin
                    errors++;
                    $display("FAIL strobe_code: sample=%h at strobe, expected %h", sample, mon_exp);
                end
            end
        end
        checks++;
        if (prev_strobe && key_strobe) begin
            errors++;
            $display("FAIL strobe_width: key_strobe high 2 cycles, expected 1");
        end
        checks++;
        if (sample inside {4'hC, 4'hD, 4'hE}) begin
            errors++;
            $display("FAIL code_range: sample=%h, expected never C..E", sample);
        end
        prev_strobe = key_strobe;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sample(input logic [3:0] want, input int budget, output int waited);
        waited = 0;
        while (sample !== want && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Model: a lone held key settles to its table code, anything else to NONE.
    function automatic logic [3:0] model_code(input logic [11:0] keys);
        logic [3:0] code;
        int         n;
        code = NONE;
        n    = 0;
        for (int i = 0; i < 12; i++) begin
            if (keys[i]) begin
                n++;
                code = key_code[i];
            end
        end
        return (n == 1) ? code : NONE;
    endfunction

    task automatic expect_keys(input logic [11:0] keys);
        logic [3:0] e;
        e = model_code(keys);
        if (e != exp_sample && e != NONE) exp_q.push_back(e);
        exp_sample = e;
        pressed    = keys;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int s0, n;
        expect_keys(12'(1 << 4));
        rst = 1'b1;
        idle(3);
        checks++;
        if (col !== 3'b110) begin errors++; $display("FAIL reset_col: col=%b expected 110", col); end
        checks++;
        if (sample !== NONE) begin errors++; $display("FAIL reset_sample: sample=%h expected F", sample); end
        checks++;
        if (key_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: key_strobe=%b expected 0", key_strobe); end

        s0  = strobe_cnt;
        rst = 1'b0;
        wait_sample(4'h5, LATENCY + 1, n);
        checks++;
        if (sample !== 4'h5) begin errors++; $display("FAIL reset_first_key: sample=%h expected 5 after %0d cycles", sample, n); end
        idle(30);
        checks++;
        if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL reset_strobe_count: %0d strobes, expected 1", strobe_cnt - s0); end

        // Reset while the key stays held: outputs clear at once, key re-debounces.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sample !== NONE || col !== 3'b110 || key_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: sample=%h col=%b strobe=%b expected F/110/0", sample, col, key_strobe);
        end
        idle(2);
        exp_q.push_back(4'h5);
        s0  = strobe_cnt;
        rst = 1'b0;
        wait_sample(4'h5, LATENCY + 1, n);
        checks++;
        if (sample !== 4'h5) begin errors++; $display("FAIL reset_rekey: sample=%h expected 5 after %0d cycles", sample, n); end
        idle(30);
        checks++;
        if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL reset_restrobe: %0d strobes, expected 1", strobe_cnt - s0); end

        expect_keys('0);
        wait_sample(NONE, LATENCY + 1, n);
        idle(10);
    endtask

    task automatic test_press_release();
        int s0, n;
        s0 = strobe_cnt;
        expect_keys(12'(1 << 4));
        wait_sample(4'h5, LATENCY + 1, n);
        checks++;
        if (sample !== 4'h5) begin errors++; $display("FAIL press_5: sample=%h expected 5 after %0d cycles", sample, n); end
        idle(100 - n);
        checks++;
        if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL hold_5_strobes: %0d strobes, expected 1", strobe_cnt - s0); end

        s0 = strobe_cnt;
        expect_keys('0);
        wait_sample(NONE, LATENCY + 1, n);
        checks++;
        if (sample !== NONE) begin errors++; $display("FAIL release_5: sample=%h expected F after %0d cycles", sample, n); end
        idle(20);
        checks++;
        if (strobe_cnt - s0 != 0) begin errors++; $display("FAIL release_strobes: %0d strobes, expected 0", strobe_cnt - s0); end
    endtask

    // Toggle period of 8 cycles against a 12-cycle frame makes every frame
    // disagree with the one before, so the bounce can never qualify.
    task automatic test_bounce();
        int   s0, n;
        logic moved;
        s0    = strobe_cnt;
        moved = 1'b0;
        for (int i = 0; i < 15; i++) begin
            pressed[7] = ~pressed[7];
            repeat (4) begin
                @(negedge clk);
                if (sample !== NONE) moved = 1'b1;
            end
        end
        checks++;
        if (moved) begin errors++; $display("FAIL bounce_sample: sample left F during bounce, expected F"); end
        checks++;
        if (strobe_cnt - s0 != 0) begin errors++; $display("FAIL bounce_strobes: %0d strobes during bounce, expected 0", strobe_cnt - s0); end

        expect_keys(12'(1 << 7));
        wait_sample(4'h8, LATENCY + 1, n);
        checks++;
        if (sample !== 4'h8) begin errors++; $display("FAIL bounce_settle: sample=%h expected 8 after %0d cycles", sample, n); end
        idle(30);
        checks++;
        if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL bounce_strobe_count: %0d strobes, expected 1", strobe_cnt - s0); end
        expect_keys('0);
        wait_sample(NONE, LATENCY + 1, n);
        idle(10);
    endtask

    task automatic test_ghost();
        int s0, n;
        s0 = strobe_cnt;
        expect_keys(12'b011);
        idle(100);
        checks++;
        if (sample !== NONE) begin errors++; $display("FAIL ghost_sample: sample=%h expected F", sample); end
        checks++;
        if (strobe_cnt - s0 != 0) begin errors++; $display("FAIL ghost_strobes: %0d strobes, expected 0", strobe_cnt - s0); end

        expect_keys(12'b001);
        wait_sample(4'h1, LATENCY + 1, n);
        checks++;
        if (sample !== 4'h1) begin errors++; $display("FAIL ghost_release: sample=%h expected 1 after %0d cycles", sample, n); end
        idle(20);
        checks++;
        if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL ghost_strobe_count: %0d strobes, expected 1", strobe_cnt - s0); end
        expect_keys('0);
        wait_sample(NONE, LATENCY + 1, n);
        idle(10);
    endtask

    task automatic test_special();
        int         s0, n;
        int         pos  [3] = '{9, 10, 11};
        logic [3:0] want [3] = '{4'hA, 4'h0, 4'hB};
        s0 = strobe_cnt;
        for (int k = 0; k < 3; k++) begin
            expect_keys(12'(1 << pos[k]));
            wait_sample(want[k], LATENCY + 1, n);
            checks++;
            if (sample !== want[k]) begin errors++; $display("FAIL special_%0d: sample=%h expected %h after %0d cycles", k, sample, want[k], n); end
            idle(20);
            expect_keys('0);
            wait_sample(NONE, LATENCY + 1, n);
            checks++;
            if (sample !== NONE) begin errors++; $display("FAIL special_release_%0d: sample=%h expected F", k, sample); end
            idle(10);
        end
        checks++;
        if (strobe_cnt - s0 != 3) begin errors++; $display("FAIL special_strobes: %0d strobes, expected 3", strobe_cnt - s0); end
    endtask

    task automatic test_back_to_back();
        int   s0, n;
        logic saw_none;
        s0 = strobe_cnt;
        expect_keys(12'(1 << 2));
        wait_sample(4'h3, LATENCY + 1, n);
        checks++;
        if (sample !== 4'h3) begin errors++; $display("FAIL rollover_3: sample=%h expected 3 after %0d cycles", sample, n); end
        idle(30);
        expect_keys(12'(1 << 5));
        saw_none = 1'b0;
        n        = 0;
        while (sample !== 4'h6 && n < LATENCY + 1) begin
            @(negedge clk);
            n++;
            if (sample === NONE) saw_none = 1'b1;
        end
        checks++;
        if (sample !== 4'h6) begin errors++; $display("FAIL rollover_6: sample=%h expected 6 after %0d cycles", sample, n); end
        checks++;
        if (saw_none) begin errors++; $display("FAIL rollover_gap: sample passed through F, expected direct 3->6"); end
        idle(30);
        checks++;
        if (strobe_cnt - s0 != 2) begin errors++; $display("FAIL rollover_strobes: %0d strobes, expected 2", strobe_cnt - s0); end
        expect_keys('0);
        wait_sample(NONE, LATENCY + 1, n);
        idle(10);
    endtask

    task automatic test_random();
        int          n, hold, a, b, kind;
        logic [11:0] keys;
        for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom_range(0, 11);
            b    = (a + $urandom_range(1, 11)) % 12;
            keys = '0;
            if (kind != 0) keys[a] = 1'b1;
            if (kind == 3) keys[b] = 1'b1;
            expect_keys(keys);
            hold = $urandom_range(60, 100);
            wait_sample(exp_sample, LATENCY + 1, n);
            checks++;
            if (sample !== exp_sample) begin
                errors++;
                $display("FAIL random_%0d: keys=%b sample=%h expected %h", i, keys, sample, exp_sample);
            end
            if (hold > n) idle(hold - n);
        end
        expect_keys('0);
        wait_sample(NONE, LATENCY + 1, n);
        idle(10);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_ghost();
        test_special();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d expected strobes never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
